// File: rtl/collor_pkg.sv
// collor_pkg: shared types and palette for the multi-channel RGB PWM driver.
//   rgb_t        - packed {r, g, b} LED drive triple
//   COLOR_*      - palette constants, indexed by colour code 0..7
//   state_t      - enable FSM encoding
//   code_to_rgb  - colour code to rgb_t lookup
package collor_pkg;

    // Widest colour code supported by the palette; narrower codes are zero-extended.
    localparam int unsigned PAL_CODE_W = 3;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t COLOR_OFF     = '{r: 1'b0, g: 1'b0, b: 1'b0};
    localparam rgb_t COLOR_GREEN   = '{r: 1'b0, g: 1'b1, b: 1'b0};
    localparam rgb_t COLOR_YELLOW  = '{r: 1'b1, g: 1'b1, b: 1'b0};
    localparam rgb_t COLOR_BLUE    = '{r: 1'b0, g: 1'b0, b: 1'b1};
    localparam rgb_t COLOR_RED     = '{r: 1'b1, g: 1'b0, b: 1'b0};
    localparam rgb_t COLOR_CYAN    = '{r: 1'b0, g: 1'b1, b: 1'b1};
    localparam rgb_t COLOR_MAGENTA = '{r: 1'b1, g: 1'b0, b: 1'b1};
    localparam rgb_t COLOR_WHITE   = '{r: 1'b1, g: 1'b1, b: 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Map a colour code onto the LED triple.
    function automatic rgb_t code_to_rgb(input logic [PAL_CODE_W-1:0] code);
        rgb_t rgb;
        case (code)
            3'd0:    rgb = COLOR_OFF;
            3'd1:    rgb = COLOR_GREEN;
            3'd2:    rgb = COLOR_YELLOW;
            3'd3:    rgb = COLOR_BLUE;
            3'd4:    rgb = COLOR_RED;
            3'd5:    rgb = COLOR_CYAN;
            3'd6:    rgb = COLOR_MAGENTA;
            3'd7:    rgb = COLOR_WHITE;
            default: rgb = COLOR_OFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/collor_pwm_cnt.sv
// collor_pwm_cnt: free-running PWM counter with duty compare.
// Counts 0 .. 2^PWM_W-2 so a brightness of all-ones is fully on with no gap.
//   clk, rst    - clock, synchronous active-high reset
//   en          - count enable; low holds the counter at 0
//   brightness  - duty threshold
//   on          - combinational compare (cnt < brightness), registered by the parent
module collor_pwm_cnt #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] brightness,
    output logic             on
);

    // Terminal count 2^PWM_W - 2 gives a period of 2^PWM_W - 1.
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;

    // Next count: hold at 0 while disabled, wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PWM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign on = (cnt_q < brightness);

endmodule

// File: rtl/collor_pwm.sv
// collor_pwm: multi-channel colour-code to RGB LED driver with shared PWM brightness.
// Each channel latches a colour code on load, maps it through the palette and
// drives its R/G/B pins gated by main_program, the PWM compare and (optionally)
// a per-channel blink gate. All LED outputs are registered.
//   clk, rst      - clock, synchronous active-high reset
//   main_program  - global enable; low forces all LEDs off
//   load          - one-cycle strobe capturing code_in and blink_in
//   code_in       - packed colour codes, channel i at [i*CODE_W +: CODE_W]
//   blink_in      - per-channel blink request
//   brightness    - shared PWM duty
//   red_led, green_led, blue_led - per-channel LED drives
// Build option: define COLLOR_BLINK_EN to add the blink timer and per-channel
// blink gating; otherwise blink_in is ignored and no blink state exists.
module collor_pwm
    import collor_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CODE_W    = 3,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       main_program,
    input  logic                       load,
    input  logic [CHANNELS*CODE_W-1:0] code_in,
    input  logic [CHANNELS-1:0]        blink_in,
    input  logic [PWM_W-1:0]           brightness,
    output logic [CHANNELS-1:0]        red_led,
    output logic [CHANNELS-1:0]        green_led,
    output logic [CHANNELS-1:0]        blue_led
);

    localparam int unsigned CODES_W = CHANNELS * CODE_W;

    state_t               state_q;
    state_t               state_d;
    logic [CODES_W-1:0]   code_q;
    logic [CODES_W-1:0]   code_d;
    logic [CHANNELS-1:0]  red_q;
    logic [CHANNELS-1:0]  red_d;
    logic [CHANNELS-1:0]  green_q;
    logic [CHANNELS-1:0]  green_d;
    logic [CHANNELS-1:0]  blue_q;
    logic [CHANNELS-1:0]  blue_d;
    logic [CHANNELS-1:0]  gate;
    logic                 pwm_on;
    logic                 run;
    rgb_t                 rgb;

    assign run = (state_q == ST_RUN);

    // PWM counter runs only in RUN, so entering RUN always starts at count 0.
    collor_pwm_cnt #(
        .PWM_W (PWM_W)
    ) u_pwm_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .brightness (brightness),
        .on         (pwm_on)
    );

`ifdef COLLOR_BLINK_EN
    localparam int unsigned TMR_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BLINK_DIV - 1);

    logic [CHANNELS-1:0] blink_q;
    logic [CHANNELS-1:0] blink_d;
    logic [TMR_W-1:0]    tmr_q;
    logic [TMR_W-1:0]    tmr_d;
    logic                phase_q;
    logic                phase_d;

    // Blink request register, timer and phase; timer and phase restart in IDLE.
    always_comb begin
        blink_d = load ? blink_in : blink_q;
        tmr_d   = tmr_q;
        phase_d = phase_q;
        if (!run) begin
            tmr_d   = '0;
            phase_d = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
            tmr_d   = '0;
            phase_d = ~phase_q;
        end else begin
            tmr_d   = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
            tmr_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
            tmr_q   <= tmr_d;
            phase_q <= phase_d;
        end
    end

    // Blinking channels are dark during the OFF phase.
    assign gate = ~blink_q | {CHANNELS{phase_q}};
`else
    logic unused_blink;

    assign unused_blink = ^{blink_in, BLINK_DIV[0]};
    assign gate         = '1;
`endif

    // Enable FSM, code capture and next LED drive.
    always_comb begin
        state_d = state_q;
        code_d  = load ? code_in : code_q;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        rgb     = COLOR_OFF;

        case (state_q)
            ST_IDLE: if (main_program)  state_d = ST_RUN;
            ST_RUN:  if (!main_program) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // main_program is used directly so a falling enable darkens on the same edge.
        if (run && main_program && pwm_on) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                rgb        = code_to_rgb(PAL_CODE_W'(code_q[i*CODE_W +: CODE_W]));
                red_d[i]   = rgb.r & gate[i];
                green_d[i] = rgb.g & gate[i];
                blue_d[i]  = rgb.b & gate[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red_led   = red_q;
    assign green_led = green_q;
    assign blue_led  = blue_q;

endmodule

// File: tb/tb_collor_pwm.sv
// tb_collor_pwm: directed plus randomized bench for collor_pwm against a
// cycle-level behavioural model (run time since enable, palette table).
module tb_collor_pwm;

    localparam int unsigned CH     = 4;
    localparam int unsigned CW     = 3;
    localparam int unsigned PW     = 4;
    localparam int unsigned BD     = 4;
    localparam int unsigned PERIOD = 15;
`ifdef COLLOR_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            main_program;
    logic            load;
    logic [CH*CW-1:0] code_in;
    logic [CH-1:0]   blink_in;
    logic [PW-1:0]   brightness;
    logic [CH-1:0]   red_led;
    logic [CH-1:0]   green_led;
    logic [CH-1:0]   blue_led;

    int total = 0;
    int bad   = 0;

    // Model state: latched codes, blink requests, run flag and edges spent in RUN.
    int       m_code [CH];
    bit       m_blink[CH];
    bit       m_run;
    int       m_t;
    logic [CH-1:0] e_r, e_g, e_b;
    // Palette as {r,g,b} per code.
    bit [2:0] pal [8] = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b100, 3'b011, 3'b101, 3'b111};

    always #5 clk = ~clk;

    collor_pwm #(
        .CHANNELS  (CH),
        .CODE_W    (CW),
        .PWM_W     (PW),
        .BLINK_DIV (BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .main_program (main_program),
        .load         (load),
        .code_in      (code_in),
        .blink_in     (blink_in),
        .brightness   (brightness),
        .red_led      (red_led),
        .green_led    (green_led),
        .blue_led     (blue_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        bit on, ph, gt;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_code[i]  = 0;
                m_blink[i] = 1'b0;
            end
            m_run = 1'b0;
            m_t   = 0;
            e_r = '0; e_g = '0; e_b = '0;
        end else begin
            e_r = '0; e_g = '0; e_b = '0;
            if (m_run && main_program) begin
                on = (m_t % PERIOD) < int'(brightness);
                ph = ((m_t / BD) % 2) == 0;
                for (int i = 0; i < CH; i++) begin
                    gt = !(BLINK_ON && m_blink[i]) || ph;
                    if (on && gt) begin
                        e_r[i] = pal[m_code[i]][2];
                        e_g[i] = pal[m_code[i]][1];
                        e_b[i] = pal[m_code[i]][0];
                    end
                end
            end
            if (load) begin
                for (int i = 0; i < CH; i++) begin
                    m_code[i]  = int'(code_in[i*CW +: CW]);
                    m_blink[i] = blink_in[i];
                end
            end
            if (m_run) begin
                if (main_program) m_t++;
                else begin
                    m_run = 1'b0;
                    m_t   = 0;
                end
            end else if (main_program) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("red", 32'(red_led), 32'(e_r));
        check("green", 32'(green_led), 32'(e_g));
        check("blue", 32'(blue_led), 32'(e_b));
    endtask

    initial begin
        int hi;
        int hi1;
        rst          = 1'b1;
        main_program = 1'b0;
        load         = 1'b0;
        code_in      = '0;
        blink_in     = '0;
        brightness   = 4'd15;
        for (int i = 0; i < CH; i++) begin
            m_code[i]  = 0;
            m_blink[i] = 1'b0;
        end
        m_run = 1'b0;
        m_t   = 0;

        // Reset, then enable with nothing loaded: all dark.
        repeat (3) tick();
        check("rst_red", 32'(red_led), 32'h0);
        rst          = 1'b0;
        main_program = 1'b1;
        repeat (4) tick();
        check("noload_green", 32'(green_led), 32'h0);

        // Palette sweep, codes 0..3 then 4..7.
        code_in = {3'd3, 3'd2, 3'd1, 3'd0};
        load    = 1'b1;
        tick();
        load    = 1'b0;
        tick();
        check("pal03_r", 32'(red_led), 32'h4);
        check("pal03_g", 32'(green_led), 32'h6);
        check("pal03_b", 32'(blue_led), 32'h8);
        code_in = {3'd7, 3'd6, 3'd5, 3'd4};
        load    = 1'b1;
        tick();
        load    = 1'b0;
        tick();
        check("pal47_r", 32'(red_led), 32'hd);
        check("pal47_g", 32'(green_led), 32'ha);
        check("pal47_b", 32'(blue_led), 32'he);

        // Duty over one full period for 5, 0 and full scale.
        brightness = 4'd5;
        hi = 0;
        repeat (PERIOD) begin tick(); hi += int'(red_led[0]); end
        check("duty5", 32'(hi), 32'd5);
        brightness = 4'd0;
        hi = 0;
        repeat (PERIOD) begin tick(); hi += int'(red_led[0]) + int'(blue_led[3]); end
        check("duty0", 32'(hi), 32'd0);
        brightness = 4'd15;
        hi = 0;
        repeat (PERIOD) begin tick(); hi += int'(red_led[0]); end
        check("duty15", 32'(hi), 32'd15);

        // Enable gating mid-PWM, then restart phase from count 0.
        brightness   = 4'd5;
        repeat (3) tick();
        main_program = 1'b0;
        tick();
        check("gate_off_r", 32'(red_led), 32'h0);
        repeat (3) tick();
        main_program = 1'b1;
        tick();
        check("reenter_r", 32'(red_led), 32'h0);
        hi = 0;
        repeat (5) begin tick(); hi += int'(red_led[0]); end
        check("restart_on5", 32'(hi), 32'd5);
        check("restart_code", 32'(green_led), 32'ha);
        hi = 0;
        repeat (10) begin tick(); hi += int'(red_led[0]); end
        check("restart_off10", 32'(hi), 32'd0);

        // Blink on channel 0 only, all white at full brightness.
        brightness = 4'd15;
        code_in    = {4{3'd7}};
        blink_in   = 4'b0001;
        load       = 1'b1;
        tick();
        load         = 1'b0;
        main_program = 1'b0;
        tick();
        main_program = 1'b1;
        tick();
        hi  = 0;
        hi1 = 0;
        repeat (16) begin
            tick();
            hi  += int'(red_led[0]);
            hi1 += int'(red_led[1]);
        end
        check("blink_ch0", 32'(hi), BLINK_ON ? 32'd8 : 32'd16);
        check("blink_ch1", 32'(hi1), 32'd16);

        // Reset mid-run with a competing load.
        repeat (3) tick();
        rst     = 1'b1;
        load    = 1'b1;
        code_in = {3'd5, 3'd6, 3'd7, 3'd2};
        tick();
        check("midrst_r", 32'(red_led), 32'h0);
        rst  = 1'b0;
        load = 1'b0;
        repeat (5) tick();
        check("midrst_code", 32'(green_led), 32'h0);

        // Randomized traffic.
        main_program = 1'b1;
        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) main_program = ~main_program;
            load     = ($urandom_range(0, 7) == 0);
            code_in  = (CH*CW)'($urandom);
            blink_in = CH'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       brightness = 4'd0;
                    1:       brightness = 4'd15;
                    default: brightness = PW'($urandom);
                endcase
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collor_pwm.md
# collor_pwm

Parametrised multi-channel successor to the single-LED colour decoder. Each channel latches a colour code on a load strobe, maps it through a fixed palette to R/G/B, and drives the three LEDs with a shared PWM brightness. Optional per-channel blinking. Sits between the main-program controller and the board RGB LED pins. All outputs are registered.

## Interface
- CHANNELS, 4: number of RGB LEDs driven.
- CODE_W, 3: colour code width per channel; must be 2 or 3.
- PWM_W, 8: brightness resolution in bits.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be ≥ 2. Used only with COLLOR_BLINK_EN.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- main_program  in  1  global enable; low forces all LEDs off.
- load  in  1  one-cycle strobe that captures code_in and blink_in.
- code_in  in  CHANNELS*CODE_W  colour codes; channel i is bits [i*CODE_W +: CODE_W].
- blink_in  in  CHANNELS  per-channel blink request; ignored without COLLOR_BLINK_EN.
- brightness  in  PWM_W  shared duty, sampled continuously.
- red_led  out  CHANNELS  red drive, one bit per channel.
- green_led  out  CHANNELS  green drive.
- blue_led  out  CHANNELS  blue drive.

## Operation
- Palette:
  - 0 = off, 1 = green, 2 = yellow (R+G), 3 = blue.
  - 4 = red, 5 = cyan (G+B), 6 = magenta (R+B), 7 = white.
  - Codes 4–7 exist only when CODE_W = 3.
- Code registers:
  - code_q[i] and blink_q[i] load only on a clock edge where load = 1.
  - Otherwise they hold.
  - load is accepted regardless of main_program.
- PWM counter:
  - Free-running from 0 up to 2^PWM_W − 2, then wraps to 0. Period is 2^PWM_W − 1.
  - Compare is on = (cnt < brightness).
  - brightness = 0 gives always off; brightness = 2^PWM_W − 1 gives always on with no gap.
- Output for each channel and colour: main_program AND palette bit AND on AND blink gate.
- FSM states and transitions:
  - IDLE → RUN on the first edge that samples main_program = 1.
  - RUN → IDLE on the first edge that samples main_program = 0.
- Behaviour in IDLE:
  - LEDs are 0.
  - PWM counter and blink timer are held at 0.
  - code_q and blink_q are retained.
- Entering RUN restarts PWM and blink from count 0, so the phase is deterministic.
- brightness changes take effect from the next compare. There is no period-boundary shadowing.

## Timing
- Reset:
  - All LED outputs are 0; code_q is 0; blink_q is 0.
  - PWM counter is 0; blink timer is 0; blink phase is ON; FSM is IDLE.
- Load latency: load sampled at edge N updates code_q at N. The LEDs show the new colour from edge N+1.
- Enable latency:
  - main_program high sampled at edge N puts the FSM in RUN at N. First LED-on is at N+1 when brightness > 0.
  - main_program low sampled at edge N forces LEDs to 0 at edge N+1 at the latest.
- Simultaneous load and main_program fall: the code is captured and the LEDs go off.
- Reset asserted mid-operation: all state returns to reset values at that edge. This overrides load.

## Configuration
- COLLOR_BLINK_EN defined:
  - A blink timer counts 0 to BLINK_DIV − 1 in RUN state.
  - At terminal count it wraps and toggles the blink phase; phase starts ON.
  - The gate for channel i is (!blink_q[i] | phase).
- COLLOR_BLINK_EN undefined:
  - No timer or phase logic.
  - Gate is constant 1, blink_in is unused, and blink_q is not instantiated.

## Structure
- Package collor_pkg holds:
  - rgb_t, a packed struct with r, g, b.
  - Palette constants COLOR_OFF through COLOR_WHITE.
  - Function code_to_rgb().
- Sub-module collor_pwm_cnt: PWM counter plus compare, parametrised by PWM_W, with en and on ports. Its en input holds the counter at 0 when low.
- Top level holds the FSM, the code and blink registers, the optional blink timer, and the output registers.

## Test plan
- Reset check, with CHANNELS=4, CODE_W=3, PWM_W=4:
  - Stimulus: rst high for 3 cycles, then main_program=1 with no load.
  - Required: all LEDs 0 throughout.
- Palette sweep, brightness=15:
  - Stimulus: load code_in = {3,2,1,0}.
  - Required from load edge +1: red_led=4'b0100, green_led=4'b0110, blue_led=4'b1000.
  - Repeat for codes 4–7 and check R, C, M, W.
- PWM duty, brightness=5:
  - Required: each lit LED is high for exactly 5 of every 15 cycles.
  - brightness=0 never lights; brightness=15 never drops.
- Enable gating:
  - Stimulus: drop main_program mid-PWM.
  - Required: LEDs 0 next edge.
  - Stimulus: re-raise main_program.
  - Required: PWM restarts at cnt 0 and code_q is unchanged.
- Blink, COLLOR_BLINK_EN with BLINK_DIV=4:
  - Stimulus: blink_in=4'b0001, brightness=15.
  - Required: channel 0 toggles every 4 cycles, starting ON; other channels stay steady.
  - Without the macro: the same stimulus gives steady output.
- Mid-run reset:
  - Stimulus: rst pulse while lit and blinking, with load asserted in the same cycle.
  - Required: all outputs 0, code_q = 0, FSM in IDLE.
